wsg_synth: RTL and testbench
============================

# wsg_synth

Parametrised N-channel wavetable sound generator for the arcade cores. It holds per-channel frequency/wave/volume registers written by the CPU bus decode and steps one phase accumulator per channel at the audio sample rate. Each tick it reads each channel's sample from the external 4-bit wave PROMs, scales and mixes the channels into one saturated signed sample, and optionally drives a 1-bit delta-sigma output pin. It is the generalised successor of the fixed 3-channel audio logic in the top level.

## Interface
- CHANNELS, 3: number of voices, 1..8
- CLK_HZ, 33330000: clk frequency in Hz
- SAMPLE_HZ, 24000: mixed output sample rate in Hz
- ACC_W, 20: phase accumulator width; also the frequency width, which is 5 nibbles
- OUT_W, 10: signed mixed-sample width
- CH_W, derived: clog2(CHANNELS), minimum 1

- clk  in  1  system clock (pixel clock domain)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run/freeze
- reg_we  in  1  register write strobe, one cycle
- reg_addr  in  CH_W+3  {channel, field}
- reg_din  in  4  register nibble
- wave_rd  out  1  PROM read strobe
- wave_addr  out  8  {wave[2:0], phase index[4:0]}
- wave_bank  out  1  wave[3], selects PROM A (0) or PROM B (1)
- wave_data  in  4  PROM data, valid the cycle after wave_rd
- sample_out  out  OUT_W  signed mixed sample
- sample_valid  out  1  one-cycle pulse on sample_out update
- pdm_out  out  1  delta-sigma bitstream

## Operation
- Register fields:
  - 0..4: frequency nibbles, 0 is least significant.
  - 5: wave select.
  - 6: volume.
  - 7: ignored.
  - Writes to a channel index >= CHANNELS are ignored.
- Registers reset to 0, so all volumes are 0 and the output is silent.
- Divider: DIV = CLK_HZ/SAMPLE_HZ, integer division. A tick is asserted for one cycle when the counter reaches DIV-1, and the counter then wraps to 0.
  - Elaboration fails when DIV < 3*CHANNELS+3.
- FSM states: IDLE, READ, WAIT, ACC, OUT.
  - IDLE: on tick with enable=1, go to READ with ch=0 and sum=0.
  - READ: drive wave_rd=1, wave_addr from ch's wave and acc[ACC_W-1 -: 5], wave_bank=wave[3]. Go to WAIT.
  - WAIT: PROM output is registered into the sample latch. Go to ACC.
  - ACC:
    - Compute signed s = wave_data-8, range -8..7.
    - Compute p = volume*s, 8-bit signed, range -120..105.
    - sum += p. sum width is 8+CH_W, sign-extended.
    - acc[ch] += freq[ch], modulo 2^ACC_W.
    - If ch == CHANNELS-1, go to OUT; otherwise ch++ and go to READ.
  - OUT: clamp sum to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register it into sample_out, pulse sample_valid. Go to IDLE.
- A register write lands immediately. A channel's new values take effect at its next READ/ACC. A write during the same cycle as that channel's ACC uses the old value.
- enable=0:
  - A tick is ignored.
  - An in-progress frame completes.
  - Accumulators and sample_out hold.
  - The divider keeps running.
- A tick arriving while not in IDLE is dropped; this cannot happen given the DIV check.

## Timing
- Reset values:
  - wave_rd=0, wave_addr=0, wave_bank=0.
  - sample_out=0, sample_valid=0, pdm_out=0.
  - All accumulators 0, FSM in IDLE, divider 0.
- Asynchronous reset mid-frame aborts the frame. No sample_valid is issued.
- Tick at cycle T (enable=1):
  - Channel c: READ at T+1+3c, WAIT at T+2+3c, ACC at T+3+3c.
  - OUT at T+1+3·CHANNELS.
  - sample_out/sample_valid visible at T+2+3·CHANNELS. For CHANNELS=3 this is 11 cycles after the tick.
- The PROM contract is 1-cycle synchronous read: address sampled at the clk edge ending READ, data held through WAIT.
- sample_valid is high for exactly one cycle per enabled tick.

## Configuration
- WSG_SIGMA_DELTA_EN defined:
  - A first-order delta-sigma modulator runs every clk on sample_out, using an OUT_W+2-bit signed accumulator with feedback ±2^(OUT_W-1).
  - pdm_out is the registered accumulator sign, inverted.
  - The ones-density of pdm_out over time equals (sample_out+2^(OUT_W-1))/2^OUT_W.
- Undefined: pdm_out is tied to 0 and no modulator logic exists. Consumers use sample_out directly.

## Test plan
- Reset, then free-run 3 ticks with no writes -> sample_out=0 and sample_valid pulses 3 times, DIV cycles apart. Assert reset mid-frame -> all outputs 0 and no pulse.
- ch0: volume=15, freq=0x00000, wave=2; PROM returns 0xF -> wave_rd at T+1 with wave_addr=0x40; sample_out=105 at T+11.
- ch0: freq=0x08000 -> wave_addr[4:0] advances by 1 every tick; after 32 ticks it wraps to 0 (accumulator wraps mod 2^20).
- OUT_W=8, all 3 channels: volume=15, PROM returns 0x0 -> sum=-360, sample_out clamps to -128. With PROM returning 0xF -> clamps to +127.
- enable=0 for 5 ticks -> no wave_rd, no sample_valid, phase unchanged. Re-enable -> resumes at the same wave_addr.
- WSG_SIGMA_DELTA_EN defined, sample_out held at +256 (OUT_W=10) -> pdm_out ones-density 0.75 ±1/1024 over 4096 cycles. Undefined -> pdm_out is constant 0.

Source files
------------

// File: rtl/wsg_synth.sv
// wsg_synth -- N-channel wavetable sound generator.
//
// Each channel has a 20-bit frequency word, a 4-bit wave select and a 4-bit
// volume, all written one nibble at a time by the CPU bus decode. Once per
// sample tick the channels are visited in order. For each channel a 4-bit
// sample is fetched from the external wave PROMs, scaled by the volume and
// summed. The phase accumulator then advances by the frequency word. The sum
// is saturated to OUT_W bits and published on sample_out.
//
// Optional feature (compile-time macro): WSG_SIGMA_DELTA_EN
//   defined   : first-order delta-sigma modulator on sample_out drives pdm_out
//   undefined : pdm_out is tied low and no modulator logic is built
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       run (1) / freeze (0); a frame already in progress completes
//   reg_we       register write strobe, one cycle
//   reg_addr     {channel, field}: field 0..4 freq nibbles, 5 wave, 6 volume
//   reg_din      register nibble
//   wave_rd      PROM read strobe
//   wave_addr    {wave[2:0], phase index[4:0]}
//   wave_bank    wave[3]: PROM A (0) or PROM B (1)
//   wave_data    PROM data, valid the cycle after wave_rd
//   sample_out   signed saturated mixed sample
//   sample_valid one-cycle pulse when sample_out updates
//   pdm_out      delta-sigma bitstream (constant 0 when the modulator is absent)
module wsg_synth #(
  parameter int CHANNELS  = 3,
  parameter int CLK_HZ    = 33330000,
  parameter int SAMPLE_HZ = 24000,
  parameter int ACC_W     = 20,
  parameter int OUT_W     = 10,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    reg_we,
  input  logic [CH_W+2:0]         reg_addr,
  input  logic [3:0]              reg_din,
  output logic                    wave_rd,
  output logic [7:0]              wave_addr,
  output logic                    wave_bank,
  input  logic [3:0]              wave_data,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    pdm_out
);

  localparam int DIV     = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W   = (DIV > 2) ? $clog2(DIV) : 2;
  localparam int SUM_W   = 8 + CH_W;
  localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(1 << (OUT_W - 1));

  // A frame needs 3 cycles per channel plus entry and output; a shorter
  // divider would drop ticks.
  if (DIV < 3 * CHANNELS + 3) begin : g_div_check
    $error("wsg_synth: CLK_HZ/SAMPLE_HZ too small for CHANNELS");
  end
  if (ACC_W < 20) begin : g_acc_check
    $error("wsg_synth: ACC_W must hold the five frequency nibbles");
  end

  typedef enum logic [2:0] {IDLE, READ, WAIT, ACC, OUT} state_t;

  state_t                  state_reg, state_next;
  logic [CH_W-1:0]         ch_reg, ch_next;
  logic signed [SUM_W-1:0] sum_reg, sum_next;
  logic [3:0]              latch_reg, latch_next;
  logic signed [OUT_W-1:0] sample_out_reg, sample_next;
  logic                    sample_valid_reg, valid_next;
  logic [DIV_W-1:0]        div_cnt_reg;
  logic                    tick;

  logic [ACC_W-1:0] acc_arr  [CHANNELS];
  logic [3:0]       wave_arr [CHANNELS];
  logic [3:0]       vol_arr  [CHANNELS];

  logic signed [8:0] vol9, s9, prod;
  int                sum_i;

  // Sample-rate divider: free-running regardless of enable.
  assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // Per-channel register file and phase accumulator. A write in the same
  // cycle as the channel's ACC step lands after that step uses the old value.
  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [ACC_W-1:0] freq_reg, acc_reg;
    logic [3:0]       wave_reg, vol_reg;
    logic             sel_wr, sel_acc;

    assign sel_wr  = reg_we && (reg_addr[CH_W+2:3] == CH_W'(gi));
    assign sel_acc = (state_reg == ACC) && (ch_reg == CH_W'(gi));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        freq_reg <= '0;
        acc_reg  <= '0;
        wave_reg <= '0;
        vol_reg  <= '0;
      end else begin
        if (sel_wr) begin
          case (reg_addr[2:0])
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: freq_reg[{reg_addr[2:0], 2'b00} +: 4] <= reg_din;
            3'd5:    wave_reg <= reg_din;
            3'd6:    vol_reg  <= reg_din;
            default: ;
          endcase
        end
        if (sel_acc) begin
          acc_reg <= acc_reg + freq_reg;
        end
      end
    end

    assign acc_arr[gi]  = acc_reg;
    assign wave_arr[gi] = wave_reg;
    assign vol_arr[gi]  = vol_reg;
  end

  // Signed sample s = data - 8 is the data with its MSB inverted.
  assign s9   = {{6{~latch_reg[3]}}, latch_reg[2:0]};
  assign vol9 = {5'b0, vol_arr[ch_reg]};
  assign prod = vol9 * s9;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      ch_reg           <= '0;
      sum_reg          <= '0;
      latch_reg        <= '0;
      sample_out_reg   <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ch_reg           <= ch_next;
      sum_reg          <= sum_next;
      latch_reg        <= latch_next;
      sample_out_reg   <= sample_next;
      sample_valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ch_next     = ch_reg;
    sum_next    = sum_reg;
    latch_next  = latch_reg;
    sample_next = sample_out_reg;
    valid_next  = 1'b0;
    wave_rd     = 1'b0;
    wave_addr   = '0;
    wave_bank   = 1'b0;
    sum_i       = int'(sum_reg);
    case (state_reg)
      IDLE: begin
        if (tick && enable) begin
          state_next = READ;
          ch_next    = '0;
          sum_next   = '0;
        end
      end
      READ: begin
        wave_rd    = 1'b1;
        wave_addr  = {wave_arr[ch_reg][2:0], acc_arr[ch_reg][ACC_W-1 -: 5]};
        wave_bank  = wave_arr[ch_reg][3];
        state_next = WAIT;
      end
      WAIT: begin
        latch_next = wave_data;
        state_next = ACC;
      end
      ACC: begin
        sum_next = sum_reg + SUM_W'(prod);
        if (ch_reg == CH_W'(CHANNELS - 1)) begin
          state_next = OUT;
        end else begin
          ch_next    = ch_reg + 1'b1;
          state_next = READ;
        end
      end
      OUT: begin
        if (sum_i > OUT_MAX) begin
          sample_next = OUT_W'(OUT_MAX);
        end else if (sum_i < OUT_MIN) begin
          sample_next = OUT_W'(OUT_MIN);
        end else begin
          sample_next = OUT_W'(sum_i);
        end
        valid_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sample_out   = sample_out_reg;
  assign sample_valid = sample_valid_reg;

`ifdef WSG_SIGMA_DELTA_EN
  // First-order modulator: subtract +half while the accumulator is
  // non-negative, add half otherwise. pdm_reg equals the inverted sign of
  // the registered accumulator but starts at 0 out of reset.
  localparam int SD_W = OUT_W + 2;
  localparam logic signed [SD_W-1:0] SD_HALF = SD_W'(1 << (OUT_W - 1));

  logic signed [SD_W-1:0] sd_acc_reg, sd_acc_next;
  logic                   pdm_reg;

  always_comb begin
    sd_acc_next = sd_acc_reg + SD_W'(sample_out_reg) - (pdm_reg ? SD_HALF : -SD_HALF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_acc_reg <= '0;
      pdm_reg    <= 1'b0;
    end else begin
      sd_acc_reg <= sd_acc_next;
      pdm_reg    <= ~sd_acc_next[SD_W-1];
    end
  end

  assign pdm_out = pdm_reg;
`else
  assign pdm_out = 1'b0;
`endif

endmodule

// File: tb/tb_wsg_synth.sv
module tb_wsg_synth;

  localparam int CH    = 3;
  localparam int DIV   = 24;
  localparam int OUT_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              reg_we = 1'b0;
  logic [4:0]        reg_addr = '0;
  logic [3:0]        reg_din = '0;
  logic              wave_rd;
  logic [7:0]        wave_addr;
  logic              wave_bank;
  logic [3:0]        wave_data;
  logic signed [7:0] sample_out;
  logic              sample_valid;
  logic              pdm_out;

  wsg_synth #(
    .CHANNELS  (CH),
    .CLK_HZ    (2400),
    .SAMPLE_HZ (100),
    .ACC_W     (20),
    .OUT_W     (OUT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_din      (reg_din),
    .wave_rd      (wave_rd),
    .wave_addr    (wave_addr),
    .wave_bank    (wave_bank),
    .wave_data    (wave_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .pdm_out      (pdm_out)
  );

  always #5 clk = ~clk;

  // PROM model: 1-cycle synchronous read returning a uniform value.
  logic [3:0] prom_val = 4'h0;
  logic [3:0] prom_q = 4'h0;
  always @(posedge clk) if (wave_rd) prom_q <= prom_val;
  assign wave_data = prom_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboards and bench model
  int exp_q[$];
  int addr_q[$];
  int m_vol[CH];
  int m_wave0 = 0;
  int m_acc0 = 0;
  int m_freq0 = 0;

  function automatic int exp_sample();
    int s = 0;
    for (int c = 0; c < CH; c++) s += m_vol[c] * (int'(prom_val) - 8);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  // Monitor, sampling on the falling edge
  int cyc = 0, n_valid = 0, n_rd = 0, rd_in_frame = 0, rd_first_cyc = 0;
  int prev_valid_cyc = -1;
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      rd_in_frame = 0;
      prev_valid_cyc = -1;
    end else begin
      if (!enable) prev_valid_cyc = -1;
      if (wave_rd) begin
        n_rd++;
        if (rd_in_frame == 0) begin
          rd_first_cyc = cyc;
          if (addr_q.size() > 0) chk("wave_addr_ch0", int'({wave_bank, wave_addr}), addr_q.pop_front());
        end
        rd_in_frame++;
      end
      if (sample_valid) begin
        n_valid++;
        chk("sb_has_entry", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          int e;
          e = exp_q.pop_front();
          chk("sample_out", int'(sample_out), e);
          $display("sample_valid at cyc %0d: sample_out=%0d expected=%0d", cyc, sample_out, e);
        end
        chk("rd_to_valid", cyc - rd_first_cyc, 3 * CH + 1);
        chk("reads_per_frame", rd_in_frame, CH);
        if (prev_valid_cyc >= 0) chk("valid_interval", cyc - prev_valid_cyc, DIV);
        prev_valid_cyc = cyc;
        rd_in_frame = 0;
      end
    end
  end

  task automatic wr(input int ch, input int field, input int val);
    @(negedge clk);
    reg_we = 1'b1;
    reg_addr = 5'(ch * 8 + field);
    reg_din = 4'(val);
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  // Queue n frames of expectations, run enabled until they drain, then freeze.
  task automatic run_ticks(input int n, input bit check_addr, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_sample());
      if (check_addr) addr_q.push_back((m_wave0 / 8) * 256 + (m_wave0 % 8) * 32 + ((m_acc0 >> 15) & 31));
      m_acc0 = (m_acc0 + m_freq0) & 32'hFFFFF;
    end
    enable = 1'b1;
    for (int i = 0; i < DIV * (n + 3) && exp_q.size() > 0; i++) @(negedge clk);
    enable = 1'b0;
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_addr_drained"}, addr_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_wave_rd"}, int'(wave_rd), 0);
    chk({tag, "_wave_addr"}, int'(wave_addr), 0);
    chk({tag, "_wave_bank"}, int'(wave_bank), 0);
    chk({tag, "_sample_out"}, int'(sample_out), 0);
    chk({tag, "_sample_valid"}, int'(sample_valid), 0);
    chk({tag, "_pdm_out"}, int'(pdm_out), 0);
  endtask

  initial begin
    int v0, r0, ones;
    bit seen;
    for (int c = 0; c < CH; c++) m_vol[c] = 0;

    // Reset state, then three silent frames DIV cycles apart
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    run_ticks(3, 1'b0, "silent");

    // ch0: volume 15, freq 0, wave 2, PROM 0xF -> 105 at address 0x40
    prom_val = 4'hF;
    wr(0, 6, 15); m_vol[0] = 15;
    wr(0, 5, 2);  m_wave0 = 2;
    run_ticks(2, 1'b1, "ch0_basic");

    // Reset in the middle of a frame
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < DIV * 3 && !seen; i++) begin
      @(negedge clk);
      if (wave_rd) seen = 1'b1;
    end
    chk("midframe_rd_seen", int'(seen), 1);
    v0 = n_valid;
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    chk("abort_no_pulse", n_valid - v0, 0);
    for (int c = 0; c < CH; c++) m_vol[c] = 0;
    m_wave0 = 0; m_acc0 = 0; m_freq0 = 0;

    // ch0 freq 0x08000 on bank B: phase index steps by 1 and wraps after 32
    wr(0, 6, 15); m_vol[0] = 15;
    wr(0, 5, 10); m_wave0 = 10;
    wr(0, 3, 8);  m_freq0 = 32'h08000;
    wr(3, 6, 15);  // channel beyond CHANNELS: ignored
    wr(0, 7, 15);  // field 7: ignored
    run_ticks(34, 1'b1, "phase");

    // Frozen for 5 ticks: no reads, no samples; phase resumes afterwards
    r0 = n_rd; v0 = n_valid;
    repeat (5 * DIV) @(negedge clk);
    chk("frozen_reads", n_rd - r0, 0);
    chk("frozen_valids", n_valid - v0, 0);
    run_ticks(2, 1'b1, "resume");

    // Saturation with all channels at full volume, plus a mixed pattern
    wr(1, 6, 15); m_vol[1] = 15;
    wr(2, 6, 15); m_vol[2] = 15;
    prom_val = 4'h0;
    run_ticks(2, 1'b0, "clamp_neg");
    prom_val = 4'hF;
    run_ticks(1, 1'b0, "clamp_pos");
    prom_val = 4'h6;
    wr(1, 6, 7); m_vol[1] = 7;
    wr(2, 6, 3); m_vol[2] = 3;
    run_ticks(1, 1'b0, "mix");

    // Hold sample_out at 105 and observe pdm_out
    prom_val = 4'hF;
    wr(1, 6, 0); m_vol[1] = 0;
    wr(2, 6, 0); m_vol[2] = 0;
    run_ticks(1, 1'b0, "pdm_setup");
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
`ifdef WSG_SIGMA_DELTA_EN
    // density (105+128)/256 -> 3728 ones in 4096 cycles
    chk("pdm_ones_near_3728", int'(ones >= 3724 && ones <= 3732), 1);
    $display("pdm ones over 4096 cycles: %0d", ones);
`else
    chk("pdm_ones", ones, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
